example_soc_boot: RTL and testbench

- Boot/housekeeping controller inside the example SoC.
- After reset it performs these steps in order:
  - powers the SD card;
  - prints a banner on the boot UART;
  - runs an image-load handshake with the SD-to-SDRAM loader;
  - prints "OK";
  - releases the CPU and asserts w_init_done.
- It muxes the serial TX line between the boot UART and the CPU UART, shows the phase on the LEDs, and drives a MAX7219 display with the phase number.

---
 rtl/example_soc_boot.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_example_soc_boot.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/example_soc_boot.sv
// Boot/housekeeping controller: SD power-up, boot banner, loader handshake, CPU release,
// TX muxing, phase LEDs and a MAX7219 phase display.
module example_soc_boot #(
  parameter int CLK_MHZ  = 27,
  parameter int BAUD     = 115200,
  parameter int PWR_WAIT = 1024,
  parameter int SPI_DIV  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_tx,
  input  logic       ld_done,
  input  logic       w_btnl,
  input  logic       w_btnr,
  output logic       o_tx,
  output logic       w_txd,
  output logic       w_init_done,
  output logic       cpu_rst_n,
  output logic       ld_start,
  output logic       sdcard_pwr_n,
  output logic [5:0] w_led,
  output logic       MAX7219_CLK,
  output logic       MAX7219_DATA,
  output logic       MAX7219_LOAD
);

  localparam int DIV   = CLK_MHZ * 1000000 / BAUD;
  localparam int DIV_W = $clog2(DIV + 1);
  localparam int PWR_W = $clog2(PWR_WAIT + 1);
  localparam int SPI_W = $clog2(SPI_DIV + 1);

  // Encodings double as the displayed phase number P.
  typedef enum logic [2:0] {
    S_PWR = 3'd1, S_BANNER = 3'd2, S_LOAD = 3'd3, S_OK = 3'd4, S_RUN = 3'd5
  } state_e;

  typedef enum logic [1:0] {SPI_IDLE, SPI_SHIFT, SPI_LATCH} spi_e;

  function automatic logic [7:0] msg_byte(input state_e st, input logic [2:0] idx);
    if (st == S_BANNER) begin
      case (idx)
        3'd0:    return 8'h42;
        3'd1:    return 8'h4F;
        3'd2:    return 8'h4F;
        3'd3:    return 8'h54;
        3'd4:    return 8'h0D;
        default: return 8'h0A;
      endcase
    end else begin
      case (idx)
        3'd0:    return 8'h4F;
        3'd1:    return 8'h4B;
        3'd2:    return 8'h0D;
        default: return 8'h0A;
      endcase
    end
  endfunction

  function automatic logic [15:0] spi_init_word(input logic [2:0] idx);
    case (idx)
      3'd0:    return 16'h0C01;
      3'd1:    return 16'h0B00;
      3'd2:    return 16'h09FF;
      3'd3:    return 16'h0A08;
      default: return 16'h0F00;
    endcase
  endfunction

  state_e           state_q, state_d;
  logic [PWR_W-1:0] pwr_cnt_q, pwr_cnt_d;
  logic [2:0]       btn_sync_q, btn_sync_d;
  logic             init_done_q, init_done_d;
  logic             ld_start_q, ld_start_d;
  logic             pwr_n_q, pwr_n_d;
  logic [5:0]       led_q, led_d;

  logic             tx_busy_q, tx_busy_d;
  logic [9:0]       tx_shift_q, tx_shift_d;
  logic [3:0]       tx_bit_q, tx_bit_d;
  logic [DIV_W-1:0] tx_div_q, tx_div_d;
  logic [2:0]       tx_idx_q, tx_idx_d;

  spi_e             spi_st_q, spi_st_d;
  logic [15:0]      spi_shift_q, spi_shift_d;
  logic [SPI_W-1:0] spi_div_q, spi_div_d;
  logic [4:0]       spi_tog_q, spi_tog_d;
  logic [2:0]       spi_init_q, spi_init_d;
  logic [2:0]       last_p_q, last_p_d;
  logic             pend_q, pend_d;
  logic             mclk_q, mclk_d;
  logic             mdata_q, mdata_d;
  logic             mload_q, mload_d;

  logic             press;
  logic             tx_done;
  logic             spi_start;
  logic [15:0]      spi_frame;
  logic [2:0]       cur_p;

  logic unused_btnr;
  assign unused_btnr = w_btnr;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    pwr_cnt_d   = pwr_cnt_q;
    btn_sync_d  = {btn_sync_q[1:0], w_btnl};
    tx_busy_d   = tx_busy_q;
    tx_shift_d  = tx_shift_q;
    tx_bit_d    = tx_bit_q;
    tx_div_d    = tx_div_q;
    tx_idx_d    = tx_idx_q;
    tx_done     = 1'b0;
    spi_st_d    = spi_st_q;
    spi_shift_d = spi_shift_q;
    spi_div_d   = spi_div_q;
    spi_tog_d   = spi_tog_q;
    spi_init_d  = spi_init_q;
    mclk_d      = mclk_q;
    mdata_d     = mdata_q;
    mload_d     = mload_q;
    spi_start   = 1'b0;
    spi_frame   = 16'h0000;

    press = btn_sync_q[1] & ~btn_sync_q[2];

    // Boot UART: the shift register LSB is the line, so the start bit leaves on the load edge.
    if (tx_busy_q) begin
      if (tx_div_q == DIV_W'(DIV - 1)) begin
        tx_div_d = '0;
        if (tx_bit_q == 4'd9) begin
          if (tx_idx_q == ((state_q == S_BANNER) ? 3'd5 : 3'd3)) begin
            tx_busy_d = 1'b0;
            tx_done   = 1'b1;
          end else begin
            tx_idx_d   = tx_idx_q + 3'd1;
            tx_shift_d = {1'b1, msg_byte(state_q, tx_idx_q + 3'd1), 1'b0};
            tx_bit_d   = 4'd0;
          end
        end else begin
          tx_bit_d   = tx_bit_q + 4'd1;
          tx_shift_d = {1'b1, tx_shift_q[9:1]};
        end
      end else begin
        tx_div_d = tx_div_q + DIV_W'(1);
      end
    end else if (state_q == S_BANNER || state_q == S_OK) begin
      tx_busy_d  = 1'b1;
      tx_idx_d   = 3'd0;
      tx_shift_d = {1'b1, msg_byte(state_q, 3'd0), 1'b0};
      tx_bit_d   = 4'd0;
      tx_div_d   = '0;
    end

    case (state_q)
      S_PWR: begin
        if (pwr_cnt_q == PWR_W'(PWR_WAIT - 1)) begin
          state_d   = S_BANNER;
          pwr_cnt_d = '0;
        end else begin
          pwr_cnt_d = pwr_cnt_q + PWR_W'(1);
        end
      end
      S_BANNER: if (tx_done) state_d = S_LOAD;
      // ld_start_q is high only in the first cycle here, which masks a stale ld_done.
      S_LOAD:   if (!ld_start_q && ld_done) state_d = S_OK;
      S_OK:     if (tx_done) state_d = S_RUN;
      S_RUN:    if (press) state_d = S_PWR;
      default:  state_d = S_PWR;
    endcase

    pwr_n_d     = (state_q == S_RUN) && press;
    ld_start_d  = (state_q != S_LOAD) && (state_d == S_LOAD);
    init_done_d = (state_d == S_RUN);
    led_d       = ~(6'd1 << (state_d - 3'd1));

    // Phase display: only the newest P waits while a frame is on the wire.
    cur_p    = state_q;
    last_p_d = cur_p;
    pend_d   = pend_q | (cur_p != last_p_q);

    case (spi_st_q)
      SPI_IDLE: begin
        if (spi_init_q != 3'd5) begin
          spi_start  = 1'b1;
          spi_frame  = spi_init_word(spi_init_q);
          spi_init_d = spi_init_q + 3'd1;
        end else if (pend_d) begin
          spi_start = 1'b1;
          spi_frame = {8'h01, 5'd0, cur_p};
          pend_d    = 1'b0;
        end
      end
      SPI_SHIFT: begin
        if (spi_div_q == SPI_W'(SPI_DIV - 1)) begin
          spi_div_d = '0;
          if (spi_tog_q == 5'd31) begin
            mclk_d   = 1'b0;
            mload_d  = 1'b1;
            spi_st_d = SPI_LATCH;
          end else begin
            spi_tog_d = spi_tog_q + 5'd1;
            mclk_d    = ~mclk_q;
            if (mclk_q) begin
              spi_shift_d = {spi_shift_q[14:0], 1'b0};
              mdata_d     = spi_shift_q[14];
            end
          end
        end else begin
          spi_div_d = spi_div_q + SPI_W'(1);
        end
      end
      SPI_LATCH: begin
        if (spi_div_q == SPI_W'(SPI_DIV - 1)) begin
          spi_div_d = '0;
          spi_st_d  = SPI_IDLE;
        end else begin
          spi_div_d = spi_div_q + SPI_W'(1);
        end
      end
      default: spi_st_d = SPI_IDLE;
    endcase

    if (spi_start) begin
      spi_st_d    = SPI_SHIFT;
      spi_shift_d = spi_frame;
      mdata_d     = spi_frame[15];
      mload_d     = 1'b0;
      mclk_d      = 1'b0;
      spi_div_d   = '0;
      spi_tog_d   = 5'd0;
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_PWR;
      pwr_cnt_q   <= '0;
      btn_sync_q  <= 3'b000;
      init_done_q <= 1'b0;
      ld_start_q  <= 1'b0;
      pwr_n_q     <= 1'b1;
      led_q       <= 6'b111111;
      tx_busy_q   <= 1'b0;
      tx_shift_q  <= 10'h3FF;
      tx_bit_q    <= 4'd0;
      tx_div_q    <= '0;
      tx_idx_q    <= 3'd0;
      spi_st_q    <= SPI_IDLE;
      spi_shift_q <= 16'h0000;
      spi_div_q   <= '0;
      spi_tog_q   <= 5'd0;
      spi_init_q  <= 3'd0;
      last_p_q    <= 3'd1;
      pend_q      <= 1'b1;
      mclk_q      <= 1'b0;
      mdata_q     <= 1'b0;
      mload_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      pwr_cnt_q   <= pwr_cnt_d;
      btn_sync_q  <= btn_sync_d;
      init_done_q <= init_done_d;
      ld_start_q  <= ld_start_d;
      pwr_n_q     <= pwr_n_d;
      led_q       <= led_d;
      tx_busy_q   <= tx_busy_d;
      tx_shift_q  <= tx_shift_d;
      tx_bit_q    <= tx_bit_d;
      tx_div_q    <= tx_div_d;
      tx_idx_q    <= tx_idx_d;
      spi_st_q    <= spi_st_d;
      spi_shift_q <= spi_shift_d;
      spi_div_q   <= spi_div_d;
      spi_tog_q   <= spi_tog_d;
      spi_init_q  <= spi_init_d;
      last_p_q    <= last_p_d;
      pend_q      <= pend_d;
      mclk_q      <= mclk_d;
      mdata_q     <= mdata_d;
      mload_q     <= mload_d;
    end
  end

  assign w_txd        = tx_shift_q[0];
  assign o_tx         = init_done_q ? uart_tx : tx_shift_q[0];
  assign w_init_done  = init_done_q;
  assign cpu_rst_n    = init_done_q;
  assign ld_start     = ld_start_q;
  assign sdcard_pwr_n = pwr_n_q;
  assign w_led        = led_q;
  assign MAX7219_CLK  = mclk_q;
  assign MAX7219_DATA = mdata_q;
  assign MAX7219_LOAD = mload_q;

endmodule

// File: tb/tb_example_soc_boot.sv
// Scoreboard bench: dut1 (DIV=4, PWR_WAIT=8) covers boot sequencing and UART;
// dut2 (PWR_WAIT=1024, SPI_DIV=1) keeps each phase long enough to see every display frame.
module tb_example_soc_boot;

  typedef struct {
    logic [7:0] data;
    bit         chained;
  } uart_exp_t;

  logic clk = 1'b0;
  logic rst_n, rst2_n, uart_tx, ld_done, ld_done2, btnl, btnr;

  logic       o_tx1, txd1, init1, cpu1, lds1, pwrn1, mclk1, mdata1, mload1;
  logic [5:0] led1;
  logic       o_tx2, txd2, init2, cpu2, lds2, pwrn2, mclk2, mdata2, mload2;
  logic [5:0] led2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ld_pulses = 0;
  bit mon_en = 1'b1;

  uart_exp_t   exp_uart[$];
  logic [15:0] exp_spi[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (lds1 === 1'b1) ld_pulses <= ld_pulses + 1;

  example_soc_boot #(.CLK_MHZ(1), .BAUD(250000), .PWR_WAIT(8), .SPI_DIV(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .uart_tx(uart_tx), .ld_done(ld_done), .w_btnl(btnl),
    .w_btnr(btnr), .o_tx(o_tx1), .w_txd(txd1), .w_init_done(init1), .cpu_rst_n(cpu1),
    .ld_start(lds1), .sdcard_pwr_n(pwrn1), .w_led(led1), .MAX7219_CLK(mclk1),
    .MAX7219_DATA(mdata1), .MAX7219_LOAD(mload1)
  );

  example_soc_boot #(.CLK_MHZ(1), .BAUD(250000), .PWR_WAIT(1024), .SPI_DIV(1)) u_dut2 (
    .clk(clk), .rst_n(rst2_n), .uart_tx(uart_tx), .ld_done(ld_done2), .w_btnl(btnr),
    .w_btnr(btnr), .o_tx(o_tx2), .w_txd(txd2), .w_init_done(init2), .cpu_rst_n(cpu2),
    .ld_start(lds2), .sdcard_pwr_n(pwrn2), .w_led(led2), .MAX7219_CLK(mclk2),
    .MAX7219_DATA(mdata2), .MAX7219_LOAD(mload2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_msg(input bit banner);
    logic [7:0] bb[6] = '{8'h42, 8'h4F, 8'h4F, 8'h54, 8'h0D, 8'h0A};
    logic [7:0] ok[4] = '{8'h4F, 8'h4B, 8'h0D, 8'h0A};
    uart_exp_t e;
    for (int i = 0; i < (banner ? 6 : 4); i++) begin
      e.data    = banner ? bb[i] : ok[i];
      e.chained = (i != 0);
      exp_uart.push_back(e);
    end
  endtask

  // UART monitor on dut1: detect start bit, sample mid-bit, compare against the scoreboard.
  initial begin : uart_mon
    logic      prev;
    logic [7:0] b;
    logic      framing;
    int        start, last_start;
    uart_exp_t e;
    prev = 1'b1;
    last_start = 0;
    forever begin
      @(negedge clk);
      if (rst_n && prev && !txd1) begin
        start = cyc;
        repeat (2) @(negedge clk);
        framing = (txd1 == 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (4) @(negedge clk);
          b[i] = txd1;
        end
        repeat (4) @(negedge clk);
        framing = framing & txd1;
        if (mon_en) begin
          if (exp_uart.size() == 0) begin
            check("uart_extra_byte", exp_uart.size(), 1);
          end else begin
            e = exp_uart.pop_front();
            check("uart_byte", {23'd0, framing, b}, {23'd0, 1'b1, e.data});
            if (e.chained) check("uart_gap", start - last_start, 40);
          end
        end
        last_start = start;
      end
      prev = txd1;
    end
  end

  // SPI monitor on dut2: shift on CLK rise, compare on LOAD rise.
  initial begin : spi_mon
    logic [15:0] sr;
    int bits;
    sr = 16'h0;
    bits = 0;
    forever begin
      @(posedge mclk2 or posedge mload2);
      if (mload2) begin
        if (bits > 0) begin
          check("spi_bit_count", bits, 16);
          if (exp_spi.size() == 0) check("spi_extra_frame", exp_spi.size(), 1);
          else check("spi_frame", sr, exp_spi.pop_front());
        end
        bits = 0;
      end else begin
        sr = {sr[14:0], mdata2};
        bits++;
      end
    end
  end

  initial begin : main
    logic [15:0] spi_list[10] = '{16'h0C01, 16'h0B00, 16'h09FF, 16'h0A08, 16'h0F00,
                                 16'h0101, 16'h0102, 16'h0103, 16'h0104, 16'h0105};
    int k, c1, c_start, mism, tx_act;
    rst_n = 1'b0; rst2_n = 1'b0; uart_tx = 1'b0; ld_done = 1'b0; ld_done2 = 1'b1;
    btnl = 1'b0; btnr = 1'b0;
    foreach (spi_list[i]) exp_spi.push_back(spi_list[i]);
    repeat (3) @(negedge clk);

    check("rst_txd", txd1, 1'b1);
    check("rst_init_done", init1, 1'b0);
    check("rst_cpu_rst_n", cpu1, 1'b0);
    check("rst_ld_start", lds1, 1'b0);
    check("rst_sd_pwr_n", pwrn1, 1'b1);
    check("rst_led", led1, 6'b111111);
    check("rst_max", {mclk1, mdata1, mload1}, 3'b001);

    push_msg(1'b1);
    rst_n = 1'b1; rst2_n = 1'b1;
    @(negedge clk);
    c1 = cyc;
    check("pwr_on_first_cycle", pwrn1, 1'b0);
    check("led_phase1", led1, 6'b111110);

    k = 0;
    while (txd1 !== 1'b0 && k < 20) begin @(negedge clk); k++; end
    check("start_bit_delay", cyc - c1, 8);
    check("led_phase2", led1, 6'b111101);

    c_start = cyc; mism = 0; k = 0;
    while (lds1 !== 1'b1 && k < 400) begin
      if (o_tx1 !== txd1) mism++;
      @(negedge clk); k++;
    end
    check("ld_start_seen", lds1, 1'b1);
    check("ld_start_after_banner", cyc - c_start, 240);
    check("otx_eq_txd_preinit", mism, 0);
    check("banner_bytes_done", exp_uart.size(), 0);
    @(negedge clk);
    check("ld_start_width", lds1, 1'b0);

    tx_act = 0;
    for (int i = 0; i < 100; i++) begin
      if (txd1 !== 1'b1) tx_act++;
      if (i == 40) btnl = 1'b1;
      if (i == 44) btnl = 0;
      @(negedge clk);
    end
    check("load_wait_led", led1, 6'b111011);
    check("load_wait_no_tx", tx_act, 0);
    check("ld_start_pulse_count", ld_pulses, 1);
    check("load_btn_ignored", init1, 1'b0);

    push_msg(1'b0);
    ld_done = 1'b1;
    k = 0;
    while (init1 !== 1'b1 && k < 400) begin @(negedge clk); k++; end
    check("init_done", init1, 1'b1);
    check("cpu_released", cpu1, 1'b1);
    check("led_phase5", led1, 6'b101111);
    check("ok_bytes_done", exp_uart.size(), 0);
    ld_done = 1'b0;

    for (int i = 0; i < 4; i++) begin
      uart_tx = (i % 2 == 1);
      #1 check("otx_follows_uart_tx", o_tx1, uart_tx);
      @(negedge clk);
    end

    push_msg(1'b1);
    btnl = 1'b1; k = 0;
    while (init1 !== 1'b0 && k < 6) begin
      @(negedge clk); k++;
      if (k == 2) btnl = 1'b0;
    end
    check("reboot_within_3", (k <= 3), 1'b1);
    check("reboot_cpu_reset", cpu1, 1'b0);
    check("reboot_pwr_off_pulse", pwrn1, 1'b1);
    @(negedge clk);
    check("reboot_pwr_on", pwrn1, 1'b0);
    k = 0;
    while (lds1 !== 1'b1 && k < 600) begin @(negedge clk); k++; end
    check("reboot_ld_start", lds1, 1'b1);
    check("reboot_banner_done", exp_uart.size(), 0);

    ld_done = 1'b1;
    k = 0;
    while (txd1 !== 1'b0 && k < 300) begin @(negedge clk); k++; end
    check("ok_byte_started", txd1, 1'b0);
    repeat (10) @(negedge clk);
    mon_en = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("midbyte_rst_txd", txd1, 1'b1);
    check("midbyte_rst_max", {mclk1, mload1}, 2'b01);
    check("midbyte_rst_ctrl", {init1, cpu1, lds1, pwrn1}, 4'b0001);
    check("midbyte_rst_led", led1, 6'b111111);

    k = 0;
    while (exp_spi.size() != 0 && k < 4000) begin @(negedge clk); k++; end
    check("spi_all_frames", exp_spi.size(), 0);
    check("dut2_init_done", init2, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
